// File: rtl/stopwatch_controller.sv
// Stopwatch timing/control core: 100 Hz prescaler, mm:ss.hh counter chain, run/lap/stop FSM.
// Optional STOPWATCH_WRAP_EN: wrap at 99:59.99 with a one-cycle overflow pulse instead of saturate+stop.
module stopwatch_controller #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [6:0] mins_out,
  output logic [5:0] secs_out,
  output logic [6:0] decs_out,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

  localparam logic [23:0] DIV_M1 = 24'(TICK_DIV - 1);

  state_t      r_state, w_next;
  logic [23:0] r_presc;
  logic [6:0]  r_decs, r_mins;
  logic [5:0]  r_secs;
  logic [6:0]  r_disp_decs, r_disp_mins;
  logic [5:0]  r_disp_secs;
  logic        r_running, r_lap_active, r_ovf;
  logic        w_active, w_tick, w_at_max, w_wrap, w_zero, w_inc, w_hold_disp, w_resume_ok;

  assign w_active    = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick      = w_active && (r_presc == DIV_M1);
  assign w_at_max    = (r_decs == 7'd99) && (r_secs == 6'd59) && (r_mins == 7'd99);
  assign w_wrap      = w_tick && w_at_max;
  assign w_hold_disp = (r_state == S_LAP) && (w_next == S_LAP);

`ifdef STOPWATCH_WRAP_EN
  assign w_inc       = w_tick;
  assign w_resume_ok = 1'b1;
`else
  // Saturating build: the final tick is swallowed and resume is locked out until clear.
  assign w_inc       = w_tick && !w_at_max;
  assign w_resume_ok = !r_ovf;
`endif

  always_comb begin
    w_next = r_state;
    w_zero = 1'b0;
    if (clear) begin
      w_next = S_IDLE;
      w_zero = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (start_stop) w_next = S_RUN;
        S_RUN: begin
          if (start_stop) w_next = S_STOP;
          else if (lap)   w_next = S_LAP;
        end
        S_LAP: begin
          if (start_stop) w_next = S_STOP;
          else if (lap)   w_next = S_RUN;
        end
        S_STOP: begin
          if (start_stop) begin
            if (w_resume_ok) w_next = S_RUN;
          end else if (lap) begin
            w_next = S_IDLE;
            w_zero = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
`ifndef STOPWATCH_WRAP_EN
      if (w_wrap) w_next = S_STOP;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_running    <= (w_next == S_RUN) || (w_next == S_LAP);
      r_lap_active <= (w_next == S_LAP);
    end
  end

  // Prescaler freezes outside RUN/LAP so a resume keeps the partial hundredth.
  always_ff @(posedge clk) begin
    if (reset || w_zero)  r_presc <= '0;
    else if (w_tick)      r_presc <= '0;
    else if (w_active)    r_presc <= r_presc + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || w_zero) begin
      r_decs <= '0;
      r_secs <= '0;
      r_mins <= '0;
    end else if (w_inc) begin
      if (r_decs == 7'd99) begin
        r_decs <= '0;
        if (r_secs == 6'd59) begin
          r_secs <= '0;
          r_mins <= (r_mins == 7'd99) ? 7'd0 : r_mins + 7'd1;
        end else begin
          r_secs <= r_secs + 6'd1;
        end
      end else begin
        r_decs <= r_decs + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_zero) begin
      r_disp_decs <= '0;
      r_disp_secs <= '0;
      r_disp_mins <= '0;
    end else if (!w_hold_disp) begin
      r_disp_decs <= r_decs;
      r_disp_secs <= r_secs;
      r_disp_mins <= r_mins;
    end
  end

`ifdef STOPWATCH_WRAP_EN
  // Two stages so the pulse lines up with the wrapped value reaching the display.
  logic r_wrap_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_d <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap && !clear;
      r_ovf    <= r_wrap_d && !clear;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset || clear) r_ovf <= 1'b0;
    else if (w_wrap)    r_ovf <= 1'b1;
  end
`endif

  assign mins_out   = r_disp_mins;
  assign secs_out   = r_disp_secs;
  assign decs_out   = r_disp_decs;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign overflow   = r_ovf;

endmodule
